mem_port_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the core top (inst_*/data_* handshake) and the cache/bridge.
- Grants one request per cycle, locks the grant until address acceptance, and tracks outstanding transactions in an in-order source FIFO so each mem_data_ok/mem_rdata is routed back to the requester that issued it.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core (inst_*/data_* requesters), the arbiter and the downstream memory port.
// slave is the arbiter's view; master is the surrounding core/memory environment's view.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_cache;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_cache;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_cache, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_cache, data_wr, data_wstrb, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_cache, mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_cache, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_cache, data_wr, data_wstrb, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_cache, mem_wr, mem_wstrb, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store, routing returns in order.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-inst priority.
module mem_port_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned PTR_W       = $clog2(OUTSTANDING)
) (
  input  logic              clk,
  input  logic              resetn,
  mem_port_arbiter_if.slave bus,
  output logic              orphan_err
);
  localparam int unsigned     CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
  localparam logic            SRC_INST = 1'b0;
  localparam logic            SRC_DATA = 1'b1;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t                 r_state;
  logic                   r_hold_src;
  logic                   r_orphan;
  logic [OUTSTANDING-1:0] r_src_fifo;
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_count;
`ifdef MEM_ARB_RR_EN
  logic                   r_last_src;
`endif

  logic w_winner;
  logic w_full;
  logic w_empty;
  logic w_sel_src;
  logic w_sel_req;
  logic w_req;
  logic w_accept;
  logic w_head;
  logic w_pop;
  logic w_orphan;

  // Fresh arbitration winner, only used in IDLE
`ifdef MEM_ARB_RR_EN
  assign w_winner = (bus.inst_req && bus.data_req) ? ~r_last_src : bus.data_req;
`else
  assign w_winner = bus.data_req;
`endif

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_sel_src = (r_state == ST_HOLD) ? r_hold_src : w_winner;
  assign w_sel_req = (r_state == ST_HOLD) ? (r_hold_src ? bus.data_req : bus.inst_req)
                                          : (bus.inst_req || bus.data_req);
  assign w_req     = resetn && !w_full && w_sel_req;
  assign w_accept  = w_req && bus.mem_addr_ok;
  assign w_head    = r_src_fifo[r_rptr];
  assign w_pop     = resetn && bus.mem_data_ok && !w_empty;
  assign w_orphan  = bus.mem_data_ok && w_empty;

  // Downstream request mux; inst path carries fixed read-word attributes
  assign bus.mem_req   = w_req;
  assign bus.mem_cache = w_sel_src ? bus.data_cache : bus.inst_cache;
  assign bus.mem_wr    = w_sel_src && bus.data_wr;
  assign bus.mem_wstrb = w_sel_src ? bus.data_wstrb : 4'h0;
  assign bus.mem_size  = w_sel_src ? bus.data_size : 3'd2;
  assign bus.mem_addr  = w_sel_src ? bus.data_addr : bus.inst_addr;
  assign bus.mem_wdata = w_sel_src ? bus.data_wdata : 32'h0;

  assign bus.inst_addr_ok = w_accept && (w_sel_src == SRC_INST);
  assign bus.data_addr_ok = w_accept && (w_sel_src == SRC_DATA);
  assign bus.inst_data_ok = w_pop && (w_head == SRC_INST);
  assign bus.data_data_ok = w_pop && (w_head == SRC_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;
  assign orphan_err       = r_orphan;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_hold_src <= SRC_INST;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_orphan   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_src <= SRC_INST;
`endif
    end else begin
      // Grant stays locked on the held source until accepted or withdrawn
      case (r_state)
        ST_IDLE: if (w_req && !bus.mem_addr_ok) begin
          r_state    <= ST_HOLD;
          r_hold_src <= w_winner;
        end
        ST_HOLD: if (w_accept || !w_sel_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_src_fifo[r_wptr] <= w_sel_src;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);

      if (w_accept && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_accept && w_pop) r_count <= r_count - CNT_W'(1);

      if (w_orphan) r_orphan <= 1'b1;
`ifdef MEM_ARB_RR_EN
      if (w_accept) r_last_src <= w_sel_src;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (OUTSTANDING = 4).
// Expectations follow MEM_ARB_RR_EN when the bench is compiled with it.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic orphan_err;
  int   n_pass  = 0;
  int   n_total = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.OUTSTANDING(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.inst_req    = 1'b0; bus.inst_cache = 1'b0; bus.inst_addr = 32'h0;
    bus.data_req    = 1'b0; bus.data_cache = 1'b0; bus.data_wr   = 1'b0;
    bus.data_wstrb  = 4'h0; bus.data_size  = 3'd0; bus.data_addr = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
  endtask

  // Inputs change on negedge; outputs are checked 1ns later, well before the next posedge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    bus.inst_req = 1'b1; bus.data_req = 1'b1;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
    step(); step(); #1;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); else n_pass++;
    n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b00) $display("FAIL rst_addr_ok: got %b want 00", {bus.inst_addr_ok, bus.data_addr_ok}); else n_pass++;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) $display("FAIL rst_data_ok: got %b want 00", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    n_total++; if (orphan_err !== 1'b0) $display("FAIL rst_orphan: got %b want 0", orphan_err); else n_pass++;
    step();
    clear_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_single_fetch();
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00000; bus.mem_addr_ok = 1'b1;
    #1;
    n_total++; if (bus.mem_req !== 1'b1) $display("FAIL fetch_req: got %b want 1", bus.mem_req); else n_pass++;
    n_total++; if (bus.mem_addr !== 32'hBFC00000) $display("FAIL fetch_addr: got %h want bfc00000", bus.mem_addr); else n_pass++;
    n_total++; if ({bus.mem_size, bus.mem_wr, bus.mem_wstrb} !== {3'd2, 1'b0, 4'h0}) $display("FAIL fetch_attr: got %b want 010_0_0000", {bus.mem_size, bus.mem_wr, bus.mem_wstrb}); else n_pass++;
    n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) $display("FAIL fetch_addr_ok: got %b want 10", {bus.inst_addr_ok, bus.data_addr_ok}); else n_pass++;
    step();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    step();
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h3C080001;
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) $display("FAIL fetch_data_ok: got %b want 10", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    n_total++; if (bus.inst_rdata !== 32'h3C080001) $display("FAIL fetch_rdata: got %h want 3c080001", bus.inst_rdata); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_contention();
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00004;
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'hF; bus.data_size = 3'd2;
    bus.data_addr = 32'h80001000; bus.data_wdata = 32'h12345678; bus.mem_addr_ok = 1'b1;
    #1;
    n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b01) $display("FAIL cont_first_grant: got %b want 01", {bus.inst_addr_ok, bus.data_addr_ok}); else n_pass++;
    n_total++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h80001000, 32'h12345678}) $display("FAIL cont_store_bus: got %h want 8000100012345678", {bus.mem_addr, bus.mem_wdata}); else n_pass++;
    n_total++; if ({bus.mem_wr, bus.mem_wstrb} !== 5'b1_1111) $display("FAIL cont_store_attr: got %b want 11111", {bus.mem_wr, bus.mem_wstrb}); else n_pass++;
    step();
    bus.data_req = 1'b0;
    #1;
    n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) $display("FAIL cont_second_grant: got %b want 10", {bus.inst_addr_ok, bus.data_addr_ok}); else n_pass++;
    n_total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wr} !== {32'hBFC00004, 32'h0, 1'b0}) $display("FAIL cont_fetch_bus: got %h want bfc0000400000000_0", {bus.mem_addr, bus.mem_wdata, bus.mem_wr}); else n_pass++;
    step();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0;
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b01) $display("FAIL cont_ret1: got %b want 01", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    step();
    bus.mem_rdata = 32'hAABBCCDD;
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) $display("FAIL cont_ret2: got %b want 10", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    n_total++; if (bus.inst_rdata !== 32'hAABBCCDD) $display("FAIL cont_ret2_rdata: got %h want aabbccdd", bus.inst_rdata); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_hold_lock();
    step();
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00100;
    #1;
    n_total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'hBFC00100}) $display("FAIL hold_c1: got %h want 1bfc00100", {bus.mem_req, bus.mem_addr}); else n_pass++;
    step();
    bus.data_req = 1'b1; bus.data_addr = 32'h80002000;
    #1;
    n_total++; if (bus.mem_addr !== 32'hBFC00100) $display("FAIL hold_c2_addr: got %h want bfc00100", bus.mem_addr); else n_pass++;
    step();
    #1;
    n_total++; if ({bus.mem_addr, bus.mem_wr} !== {32'hBFC00100, 1'b0}) $display("FAIL hold_c3_addr: got %h want bfc00100_0", {bus.mem_addr, bus.mem_wr}); else n_pass++;
    step();
    bus.mem_addr_ok = 1'b1;
    #1;
    n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b10) $display("FAIL hold_accept: got %b want 10", {bus.inst_addr_ok, bus.data_addr_ok}); else n_pass++;
    step();
    bus.inst_req = 1'b0;
    #1;
    n_total++; if ({bus.data_addr_ok, bus.mem_addr} !== {1'b1, 32'h80002000}) $display("FAIL hold_after: got %h want 180002000", {bus.data_addr_ok, bus.mem_addr}); else n_pass++;
    step();
    bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10) $display("FAIL hold_ret1: got %b want 10", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    step();
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b01) $display("FAIL hold_ret2: got %b want 01", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    step();
    clear_inputs();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      step();
      bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00200 + 32'(i * 4); bus.mem_addr_ok = 1'b1;
      #1;
      n_total++; if (bus.inst_addr_ok !== 1'b1) $display("FAIL full_fill%0d: got %b want 1", i, bus.inst_addr_ok); else n_pass++;
    end
    step();
    #1;
    n_total++; if ({bus.mem_req, bus.inst_addr_ok} !== 2'b00) $display("FAIL full_block: got %b want 00", {bus.mem_req, bus.inst_addr_ok}); else n_pass++;
    step();
    bus.mem_data_ok = 1'b1;
    #1;
    n_total++; if ({bus.mem_req, bus.inst_data_ok} !== 2'b01) $display("FAIL full_pop_cycle: got %b want 01", {bus.mem_req, bus.inst_data_ok}); else n_pass++;
    step();
    bus.mem_data_ok = 1'b0;
    #1;
    n_total++; if ({bus.mem_req, bus.inst_addr_ok} !== 2'b11) $display("FAIL full_regrant: got %b want 11", {bus.mem_req, bus.inst_addr_ok}); else n_pass++;
    step();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if (bus.inst_data_ok !== 1'b1) $display("FAIL full_drain%0d: got %b want 1", i, bus.inst_data_ok); else n_pass++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    logic [3:0] exp_data;
`ifdef MEM_ARB_RR_EN
    exp_data = 4'b0101;
`else
    exp_data = 4'b1111;
`endif
    step();
    bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if ({bus.inst_addr_ok, bus.data_addr_ok} !== {~exp_data[i], exp_data[i]}) $display("FAIL prio_grant%0d: got %b want %b", i, {bus.inst_addr_ok, bus.data_addr_ok}, {~exp_data[i], exp_data[i]}); else n_pass++;
      step();
    end
    bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== {~exp_data[i], exp_data[i]}) $display("FAIL prio_ret%0d: got %b want %b", i, {bus.inst_data_ok, bus.data_data_ok}, {~exp_data[i], exp_data[i]}); else n_pass++;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_orphan();
    step();
    bus.mem_data_ok = 1'b1;
    #1;
    n_total++; if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) $display("FAIL orphan_no_ok: got %b want 00", {bus.inst_data_ok, bus.data_data_ok}); else n_pass++;
    step();
    bus.mem_data_ok = 1'b0;
    #1;
    n_total++; if (orphan_err !== 1'b1) $display("FAIL orphan_set: got %b want 1", orphan_err); else n_pass++;
    step(); step(); step();
    #1;
    n_total++; if (orphan_err !== 1'b1) $display("FAIL orphan_sticky: got %b want 1", orphan_err); else n_pass++;
    resetn = 1'b0;
    step();
    #1;
    n_total++; if (orphan_err !== 1'b0) $display("FAIL orphan_clear: got %b want 0", orphan_err); else n_pass++;
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_hold_lock();
    test_full();
    test_priority();
    test_orphan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
